or_64_unit: RTL and testbench
=============================

// Module: or_64_unit
// PURPOSE
//   64-bit bitwise OR datapath slice for the sequential RISC-V ALU (OR/ORI).
//   Combinational result Y = A | B is always available for the single-cycle path.
//   A one-stage registered copy with a valid bit and result flags feeds the pipelined/debug path.
//   Built structurally: 64 single-bit OR cells in a generate loop; no behavioural '|' on the full vector.
// PARAMETERS
//   WIDTH      64   operand/result width; fixed at 64, other values unsupported
// PORTS
//   clk        in   1      single clock; all state on rising edge
//   rst        in   1      synchronous reset, active-high
//   A          in   64     operand A (unsigned bit vector)
//   B          in   64     operand B
//   in_valid   in   1      A/B are to be captured this cycle
//   Y          out  64     combinational A | B
//   Y_q        out  64     registered A | B
//   out_valid  out  1      Y_q/flags valid
//   zero_q     out  1      registered (A|B) == 0
//   ones_q     out  1      registered (A|B) == all ones
//   popcnt_q   out  7      registered number of set bits in A|B (only with OR64_POPCNT_EN)
// BEHAVIOUR
//   - Y[i] = A[i] | B[i] for i = 0..63; purely combinational; zero latency; valid during reset.
//   - On a rising clk edge with rst=1: Y_q=0, out_valid=0, zero_q=0, ones_q=0, popcnt_q=0.
//   - Rising edge with rst=0, in_valid=1: Y_q<=A|B, zero_q<=~|(A|B), ones_q<=&(A|B), out_valid<=1.
//   - Rising edge with rst=0, in_valid=0: out_valid<=0; Y_q and the flags hold their values.
//   - Latency is 1 cycle from in_valid to out_valid. There is no backpressure.
//   - A new capture every cycle is allowed (throughput 1/cycle).
//   - zero_q and ones_q are mutually exclusive; both are 0 for any mixed result.
//   - rst mid-stream wins over in_valid. Data presented in the reset cycle is dropped.
//   - There are no X-propagation special cases. Unknown input bits give unknown output bits.
// CONFIGURATION
//   OR64_POPCNT_EN defined:
//     - popcnt_q is computed as an adder-tree population count of A|B, range 0..64.
//     - It is registered together with Y_q.
//   OR64_POPCNT_EN undefined:
//     - popcnt_q is still a port and is tied to 7'd0.
//     - No popcount logic is built.
//   Y, Y_q, the flags and the timing are otherwise identical in both builds.
// TESTING
//   1. A=FFFF_FFFF_FFFF_FFFF, B=AAAA_AAAA_AAAA_AAAA
//      -> Y=FFFF_FFFF_FFFF_FFFF; next cycle ones_q=1, zero_q=0, popcnt_q=64.
//   2. A=0, B=0, in_valid=1
//      -> Y=0; next cycle Y_q=0, zero_q=1, ones_q=0, out_valid=1.
//   3. A=0000_0000_0000_0001, B=0000_0000_0000_0001
//      -> Y=1; then A=1, B=0 -> Y=1; popcnt_q=1 in both cases.
//   4. A=DB6D_B6DB_6DB6_DB6D, B=AAAA_AAAA_AAAA_AAAA
//      -> Y=FBEF_BEFB_EFBE_FBEF; popcnt_q=54; zero_q=0, ones_q=0.
//   5. A=FFFF_FFFF_FFFF_FFFF, B=0
//      -> Y=all ones.
//      -> Assert rst together with in_valid: out_valid=0 and Y_q=0 the next cycle.
//   6. Back-to-back in_valid for 3 cycles with distinct operands
//      -> out_valid stays high and Y_q tracks each result 1 cycle later.
//      -> Drop in_valid: out_valid=0 and Y_q holds the last result.

Source files
------------

// File: rtl/or_64_unit.sv
// 64-bit bitwise OR slice: combinational Y plus a one-stage registered copy with valid and flags.
// Optional population count of the registered result is enabled by defining OR64_POPCNT_EN.
module or_64_unit #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             in_valid,
   output logic [WIDTH-1:0] Y,
   output logic [WIDTH-1:0] Y_q,
   output logic             out_valid,
   output logic             zero_q,
   output logic             ones_q,
   output logic [6:0]       popcnt_q
);

   logic [WIDTH-1:0] y_w;
   logic [WIDTH-1:0] y_d, y_q;
   logic             valid_q;
   logic             zero_d, zero_flag_q;
   logic             ones_d, ones_flag_q;

   // One OR cell per bit.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_or_cell
      assign y_w[gi] = A[gi] | B[gi];
   end

   assign Y = y_w;

   always_comb begin
      y_d    = y_q;
      zero_d = zero_flag_q;
      ones_d = ones_flag_q;
      if (in_valid) begin
         y_d    = y_w;
         zero_d = ~|y_w;
         ones_d = &y_w;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         y_q         <= '0;
         valid_q     <= 1'b0;
         zero_flag_q <= 1'b0;
         ones_flag_q <= 1'b0;
      end else begin
         y_q         <= y_d;
         valid_q     <= in_valid;
         zero_flag_q <= zero_d;
         ones_flag_q <= ones_d;
      end
   end

   assign Y_q       = y_q;
   assign out_valid = valid_q;
   assign zero_q    = zero_flag_q;
   assign ones_q    = ones_flag_q;

`ifdef OR64_POPCNT_EN
   logic [1:0] s1 [32];
   logic [2:0] s2 [16];
   logic [3:0] s3 [8];
   logic [4:0] s4 [4];
   logic [5:0] s5 [2];
   logic [6:0] pc_w, pc_d, pc_q;

   // Balanced adder tree: each level sums adjacent pairs, widening by one bit.
   for (genvar gi = 0; gi < 32; gi++) begin : g_l1
      assign s1[gi] = {1'b0, y_w[2*gi]} + {1'b0, y_w[2*gi+1]};
   end
   for (genvar gi = 0; gi < 16; gi++) begin : g_l2
      assign s2[gi] = {1'b0, s1[2*gi]} + {1'b0, s1[2*gi+1]};
   end
   for (genvar gi = 0; gi < 8; gi++) begin : g_l3
      assign s3[gi] = {1'b0, s2[2*gi]} + {1'b0, s2[2*gi+1]};
   end
   for (genvar gi = 0; gi < 4; gi++) begin : g_l4
      assign s4[gi] = {1'b0, s3[2*gi]} + {1'b0, s3[2*gi+1]};
   end
   for (genvar gi = 0; gi < 2; gi++) begin : g_l5
      assign s5[gi] = {1'b0, s4[2*gi]} + {1'b0, s4[2*gi+1]};
   end
   assign pc_w = {1'b0, s5[0]} + {1'b0, s5[1]};

   always_comb begin
      pc_d = pc_q;
      if (in_valid) pc_d = pc_w;
   end

   always_ff @(posedge clk) begin
      if (rst) pc_q <= '0;
      else     pc_q <= pc_d;
   end

   assign popcnt_q = pc_q;
`else
   assign popcnt_q = 7'd0;
`endif

endmodule

// File: tb/tb_or_64_unit.sv
// Self-checking bench for or_64_unit: spec vectors from a table, corner sequences, random stimulus vs a model.
module tb_or_64_unit;

   logic        clk, rst, in_valid;
   logic [63:0] A, B, Y, Y_q;
   logic        out_valid, zero_q, ones_q;
   logic [6:0]  popcnt_q;

   int unsigned nvec = 0;
   int unsigned nmis = 0;

   // Reference state, updated once per rising edge from the behavioural rules.
   logic [63:0] my;
   logic        mv, mz, mo;
   int unsigned mpc;

   or_64_unit #(.WIDTH(64)) dut (
      .clk(clk), .rst(rst), .A(A), .B(B), .in_valid(in_valid),
      .Y(Y), .Y_q(Y_q), .out_valid(out_valid), .zero_q(zero_q),
      .ones_q(ones_q), .popcnt_q(popcnt_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int unsigned pcx(input int unsigned n);
`ifdef OR64_POPCNT_EN
      return n;
`else
      return 0;
`endif
   endfunction

   function automatic int unsigned count_set(input logic [63:0] v);
      int unsigned c = 0;
      for (int i = 0; i < 64; i++) if (v[i]) c++;
      return c;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_edge(input logic [63:0] a, input logic [63:0] b,
                             input logic v, input logic r);
      logic [63:0] o;
      o = a | b;
      if (r) begin
         my = '0; mv = 1'b0; mz = 1'b0; mo = 1'b0; mpc = 0;
      end else begin
         mv = v;
         if (v) begin
            my  = o;
            mz  = (o == 64'd0);
            mo  = (o == {64{1'b1}});
            mpc = count_set(o);
         end
      end
   endtask

   task automatic cycle(input logic [63:0] a, input logic [63:0] b,
                        input logic v, input logic r);
      A = a; B = b; in_valid = v; rst = r;
      #1;
      chk("Y_comb", Y, a | b);
      @(posedge clk);
      model_edge(a, b, v, r);
      #1;
      chk("Y_q", Y_q, my);
      chk("out_valid", {63'd0, out_valid}, {63'd0, mv});
      chk("zero_q", {63'd0, zero_q}, {63'd0, mz});
      chk("ones_q", {63'd0, ones_q}, {63'd0, mo});
      chk("popcnt_q", {57'd0, popcnt_q}, 64'(pcx(mpc)));
   endtask

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] ey;
      int unsigned epc;
   } vec_t;

   vec_t tbl [6];

   initial begin
      tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_FFFF_FFFF_FFFF, 64};
      tbl[1] = '{64'h0, 64'h0, 64'h0, 0};
      tbl[2] = '{64'h1, 64'h1, 64'h1, 1};
      tbl[3] = '{64'h1, 64'h0, 64'h1, 1};
      tbl[4] = '{64'hDB6D_B6DB_6DB6_DB6D, 64'hAAAA_AAAA_AAAA_AAAA, 64'hFBEF_BEFB_EFBE_FBEF, 54};
      tbl[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64};

      A = '0; B = '0; in_valid = 1'b0; rst = 1'b1;
      // Reset with operands present: combinational Y must still work.
      cycle(64'h1234_0000_0000_00F0, 64'h0, 1'b1, 1'b1);
      cycle(64'h0, 64'h0, 1'b0, 1'b1);

      for (int i = 0; i < 6; i++) begin
         cycle(tbl[i].a, tbl[i].b, 1'b1, 1'b0);
         chk("tbl_Y", Y, tbl[i].ey);
         chk("tbl_Y_q", Y_q, tbl[i].ey);
         chk("tbl_popcnt", {57'd0, popcnt_q}, 64'(pcx(tbl[i].epc)));
         chk("tbl_flags", {62'd0, zero_q, ones_q},
             {62'd0, tbl[i].ey == 64'd0, tbl[i].ey == {64{1'b1}}});
      end

      // Reset asserted together with in_valid drops the data.
      cycle(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b1);
      chk("rst_vs_valid_ov", {63'd0, out_valid}, 64'd0);
      chk("rst_vs_valid_yq", Y_q, 64'd0);

      // Back-to-back captures, then idle holds the last result.
      cycle(64'h0000_0000_0000_00F0, 64'h0000_0000_0000_000F, 1'b1, 1'b0);
      chk("b2b_0", Y_q, 64'h0000_0000_0000_00FF);
      cycle(64'h8000_0000_0000_0000, 64'h0, 1'b1, 1'b0);
      chk("b2b_1", Y_q, 64'h8000_0000_0000_0000);
      cycle(64'h0F0F_0000_0000_0000, 64'h00F0_0000_0000_0001, 1'b1, 1'b0);
      chk("b2b_2", Y_q, 64'h0FFF_0000_0000_0001);
      cycle(64'hFFFF_FFFF_FFFF_FFFF, 64'h5555, 1'b0, 1'b0);
      chk("idle_hold", Y_q, 64'h0FFF_0000_0000_0001);
      chk("idle_ov", {63'd0, out_valid}, 64'd0);

      for (int n = 0; n < 300; n++) begin
         logic [63:0] ra, rb;
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         case ($urandom_range(0, 5))
            0: begin ra = '0; rb = '0; end
            1: ra = '1;
            2: rb = ra & {$urandom, $urandom};
            default: ;
         endcase
         cycle(ra, rb, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
